// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes + ShiftRows: one output column per cycle through four
// combinational S-boxes, full 128-bit result presented with a one-cycle done pulse.
module sub_shift_rows #(
    parameter int WORD_SIZE  = 8,
    parameter int ARRAY_SIZE = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [WORD_SIZE*ARRAY_SIZE-1:0]  state,
    output logic [WORD_SIZE*ARRAY_SIZE-1:0]  state_out,
    output logic                             done,
    output logic                             busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {8'hff - x, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic [127:0] r_in;
    logic [31:0] r_work [4];
    logic [31:0] w_col;
    logic [7:0]  w_in_b [4][4];

    // Byte view of the captured state, indexed [row][column].
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_byte
            assign w_in_b[r][c] = r_in[(15 - (r + 4*c))*8 +: 8];
        end
    end

    // Row r of output column c comes from input column (c + r) mod 4.
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic [1:0] w_src_c;
        assign w_src_c = r_cnt + 2'(r);
        assign w_col[(3-r)*8 +: 8] = sbox(w_in_b[r][w_src_c]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == 2'd3) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: capture, column accumulation and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in      <= 128'd0;
            r_cnt     <= 2'd0;
            state_out <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_work[i] <= 32'd0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_in  <= state;
                        r_cnt <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_work[r_cnt] <= w_col;
                    r_cnt         <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        // Column 3 goes straight to the output alongside the stored columns.
                        state_out <= {r_work[0], r_work[1], r_work[2], w_col};
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
